shitty_cpu_core: RTL



---
 rtl/shitty_cpu_pkg.sv | 28 ++
 rtl/cpu_imem.sv | 24 ++
 rtl/shitty_cpu_core.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/shitty_cpu_pkg.sv
// Shared definitions for the shitty_cpu core: instruction layout, opcodes, FSM states.
package shitty_cpu_pkg;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [23:0] imm;
    } instr_t;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_DELAY = 4'd1;
    localparam logic [3:0] OP_OUTI  = 4'd2;
    localparam logic [3:0] OP_JMP   = 4'd3;
    localparam logic [3:0] OP_SUBI  = 4'd4;
    localparam logic [3:0] OP_JNZ   = 4'd5;
    localparam logic [3:0] OP_LDI   = 4'd6;
    localparam logic [3:0] OP_ADDI  = 4'd7;
    localparam logic [3:0] OP_OUTR  = 4'd8;
    localparam logic [3:0] OP_HALT  = 4'd9;

    typedef enum logic [2:0] {ST_BOOT, ST_FETCH, ST_EXEC, ST_WAIT, ST_HALT} state_e;

    // Ops that name a register and therefore trap on an out-of-range rd.
    function automatic logic uses_rd(input logic [3:0] op);
        return (op >= OP_SUBI) && (op <= OP_OUTR);
    endfunction

endpackage

// File: rtl/cpu_imem.sv
// Instruction RAM: one synchronous read port, one write port; read-during-write returns old data.
module cpu_imem #(
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/shitty_cpu_core.sv
// Multi-register GPIO sequencer CPU: BOOT settle, FETCH/EXEC loop, timed WAIT, HALT with program load.
module shitty_cpu_core
    import shitty_cpu_pkg::*;
#(
    parameter int    DATA_W     = 32,
    parameter int    NUM_REGS   = 4,
    parameter int    MEM_DEPTH  = 2048,
    parameter int    GPIO_W     = 8,
    parameter int    BOOT_DELAY = 16000,
    parameter string INIT_FILE  = "",
    parameter int    PC_W       = $clog2(MEM_DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    output logic [GPIO_W-1:0] gpio_o,
    output logic              halted,
    output logic              illegal,
    output logic [PC_W-1:0]   pc_o,
    input  logic              resume,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [31:0]       prog_data
);

    // One counter serves both the boot settle and DELAY, so it must hold either range.
    localparam int CNT_W = ($clog2(BOOT_DELAY + 1) > 24) ? $clog2(BOOT_DELAY + 1) : 24;

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [PC_W-1:0]                pc_q, pc_d, pc_inc;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [GPIO_W-1:0]              gpio_q, gpio_d;
    logic                           illegal_q, illegal_d;
    logic [31:0]                    rdata;
    instr_t                         ir;
    logic [DATA_W-1:0]              imm_x, rval, reg_wd;
    logic                           rd_ok, reg_we, mem_we;

    cpu_imem #(.DEPTH(MEM_DEPTH), .AW(PC_W)) u_imem (
        .clk_i   (CLK),
        .we_i    (mem_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (pc_q),
        .rdata_o (rdata)
    );

    assign ir     = instr_t'(rdata);
    assign imm_x  = DATA_W'(ir.imm);
    assign pc_inc = (pc_q == PC_W'(MEM_DEPTH - 1)) ? '0 : pc_q + 1'b1;

    always_comb begin
        rval  = '0;
        rd_ok = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ir.rd == 4'(i)) begin
                rval  = regs_q[i];
                rd_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_d      = pc_q;
        regs_d    = regs_q;
        gpio_d    = gpio_q;
        illegal_d = illegal_q;
        reg_we    = 1'b0;
        reg_wd    = '0;
        mem_we    = 1'b0;
        case (state_q)
            ST_BOOT, ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_FETCH;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
                if (ir.op > OP_HALT || (uses_rd(ir.op) && !rd_ok)) begin
                    state_d   = ST_HALT;
                    pc_d      = pc_q;
                    illegal_d = 1'b1;
                end else begin
                    case (ir.op)
                        OP_DELAY: begin
                            cnt_d   = CNT_W'(ir.imm);
                            state_d = ST_WAIT;
                        end
                        OP_OUTI: gpio_d = GPIO_W'(ir.imm);
                        OP_JMP:  pc_d   = PC_W'(ir.imm);
                        OP_SUBI: begin
                            reg_we = 1'b1;
                            reg_wd = rval - imm_x;
                        end
                        OP_JNZ:  if (rval != '0) pc_d = pc_q - PC_W'(ir.imm);
                        OP_LDI: begin
                            reg_we = 1'b1;
                            reg_wd = imm_x;
                        end
                        OP_ADDI: begin
                            reg_we = 1'b1;
                            reg_wd = rval + imm_x;
                        end
                        OP_OUTR: gpio_d = GPIO_W'(rval);
                        OP_HALT: begin
                            state_d = ST_HALT;
                            pc_d    = pc_q;
                        end
                        default: ;
                    endcase
                end
            end
            ST_HALT: begin
                mem_we = prog_we;
                if (resume) begin
                    state_d   = ST_FETCH;
                    pc_d      = '0;
                    illegal_d = 1'b0;
                end
            end
            default: state_d = ST_BOOT;
        endcase
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_we && ir.rd == 4'(i)) regs_d[i] = reg_wd;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_BOOT;
            cnt_q     <= CNT_W'(BOOT_DELAY);
            pc_q      <= '0;
            regs_q    <= '0;
            gpio_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pc_q      <= pc_d;
            regs_q    <= regs_d;
            gpio_q    <= gpio_d;
            illegal_q <= illegal_d;
        end
    end

    assign gpio_o  = gpio_q;
    assign halted  = (state_q == ST_HALT);
    assign illegal = illegal_q;
    assign pc_o    = pc_q;

endmodule
